// File: rtl/wb_trace_buffer_pkg.sv
// Shared field layout of a trace entry: {cyc, me, we, rd[4:0], result[31:0]}.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package wb_trace_buffer_pkg;

    // Bit offsets of the entry fields, counted from the LSB.
    localparam int RES_LSB   = 0;
    localparam int RES_W     = 32;
    localparam int RD_LSB    = 32;
    localparam int RD_W      = 5;
    localparam int WE_BIT    = 37;
    localparam int ME_BIT    = 38;
    localparam int CYC_LSB   = 39;

    // Everything below the cycle stamp.
    localparam int PAYLOAD_W = CYC_LSB;

    // Payload portion of an entry. The first field is the MSB, which makes the
    // packed layout match the offsets above.
    typedef struct packed {
        logic             me;
        logic             we;
        logic [RD_W-1:0]  rd;
        logic [RES_W-1:0] result;
    } trace_payload_t;

    // Full entry width for a given cycle-stamp width.
    function automatic int entry_w(input int cyc_w);
        return cyc_w + PAYLOAD_W;
    endfunction

endpackage

// File: rtl/wb_trace_buffer_if.sv
// Debug-event inputs plus the valid/ready drain port of the trace buffer.
// Latency: n/a (wiring only).
// Backpressure: out_ready_i stalls the head entry; the debug side has no backpressure.
//
// Signals:
//   dbg_result_i / dbg_rd_i / dbg_we_i / dbg_me_i : retirement info from the core
//   out_valid_o / out_ready_i / out_entry_o        : FWFT drain handshake
// master = core/host side, slave = trace buffer.
interface wb_trace_buffer_if #(
    parameter int CYC_W = 24
);
    import wb_trace_buffer_pkg::*;

    logic [31:0]                  dbg_result_i;
    logic [4:0]                   dbg_rd_i;
    logic                         dbg_we_i;
    logic                         dbg_me_i;
    logic                         out_valid_o;
    logic                         out_ready_i;
    logic [CYC_W+PAYLOAD_W-1:0]   out_entry_o;

    modport master (
        output dbg_result_i, dbg_rd_i, dbg_we_i, dbg_me_i, out_ready_i,
        input  out_valid_o, out_entry_o
    );

    modport slave (
        input  dbg_result_i, dbg_rd_i, dbg_we_i, dbg_me_i, out_ready_i,
        output out_valid_o, out_entry_o
    );

endinterface

// File: rtl/wb_trace_buffer_fifo.sv
// Generic first-word-fall-through FIFO with level/full and a synchronous clear.
// Latency: a push is visible on head_dat the cycle after the write edge.
// Backpressure: push is ignored when full unless a pop happens in the same cycle; clr wins.
//
// Ports: clk, rst (async active-low), clr, push/push_dat, pop, valid/head_dat, level, full.
module trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic                     valid,
    output logic [WIDTH-1:0]         head_dat,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] last_q;
    logic             empty;
    logic             pop_ok;
    logic             push_ok;

    // Extra MSB on each pointer separates full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign level   = wr_ptr - rd_ptr;
    assign valid   = ~empty;

    // Storage is left unreset. Nothing in mem is observable until a push has
    // written it, so a reset would not change any output.
    always_ff @(posedge clk) begin
        if (push_ok && !clr) begin
            mem[wr_ptr[AW-1:0]] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Tracks the value shown while valid. After the FIFO empties, the output
    // keeps that value instead of exposing a stale slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= '0;
        end else if (!empty) begin
            last_q <= mem[rd_ptr[AW-1:0]];
        end
    end

    assign head_dat = empty ? last_q : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/wb_trace_buffer.sv
// Captures core retirement events (reg/mem writes) with a cycle stamp into a FWFT trace FIFO.
// Latency: event sampled at edge N is at the head (if the FIFO was empty) right after edge N.
// Backpressure: the core is never stalled; events arriving while full are dropped and counted.
//
// Ports: clk, rst (async active-low), enable_i, flush_i, bus (wb_trace_buffer_if.slave),
//        level_o, drop_cnt_o (saturating), full_o.
// Build option WB_TRACE_X0_FILTER_EN: register writes to x0 that carry no memory write
// are not treated as events. They are neither captured nor counted as drops.
module wb_trace_buffer
    import wb_trace_buffer_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int CYC_W  = 24,
    parameter int DROP_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable_i,
    input  logic                    flush_i,
    wb_trace_buffer_if.slave        bus,
    output logic [$clog2(DEPTH):0]  level_o,
    output logic [DROP_W-1:0]       drop_cnt_o,
    output logic                    full_o
);
    localparam int ENTRY_W = CYC_W + PAYLOAD_W;

    logic [CYC_W-1:0]   cyc_q;
    logic [DROP_W-1:0]  drop_q;
    logic               x0_noise;
    logic               is_event;
    logic               pop;
    logic               push;
    logic               drop;
    trace_payload_t     payload;
    logic [ENTRY_W-1:0] entry;

    // Free-running stamp. It counts edges since reset release and ignores flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cyc_q <= '0;
        else      cyc_q <= cyc_q + 1'b1;
    end

`ifdef WB_TRACE_X0_FILTER_EN
    assign x0_noise = bus.dbg_we_i & ~bus.dbg_me_i & (bus.dbg_rd_i == 5'd0);
`else
    assign x0_noise = 1'b0;
`endif

    assign is_event = enable_i & (bus.dbg_we_i | bus.dbg_me_i) & ~x0_noise;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a
    // push when the head is consumed.
    assign pop  = bus.out_valid_o & bus.out_ready_i;
    assign push = is_event & (~full_o | pop) & ~flush_i;
    assign drop = is_event & full_o & ~pop & ~flush_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_q <= '0;
        end else if (flush_i) begin
            drop_q <= '0;
        end else if (drop && !(&drop_q)) begin
            drop_q <= drop_q + 1'b1;
        end
    end

    assign payload.me     = bus.dbg_me_i;
    assign payload.we     = bus.dbg_we_i;
    assign payload.rd     = bus.dbg_rd_i;
    assign payload.result = bus.dbg_result_i;
    assign entry          = {cyc_q, payload};

    trace_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .clr      (flush_i),
        .push     (push),
        .push_dat (entry),
        .pop      (pop),
        .valid    (bus.out_valid_o),
        .head_dat (bus.out_entry_o),
        .level    (level_o),
        .full     (full_o)
    );

    assign drop_cnt_o = drop_q;

endmodule
